div_sequencer: RTL

DIV_SEQUENCER -- requirements
Module: div_sequencer

---
 rtl/div_sequencer_pkg.sv | 16 +
 rtl/div_sequencer_step.sv | 28 ++
 rtl/div_sequencer.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/div_sequencer_pkg.sv
// Shared types for the iterative divider: machine word type and divider FSM states.
package ZionDataType;

    typedef logic [31:0] CpuType;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ITER = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } DivState;

    localparam logic [1:0] DIV_OP_REM = 2'b01;
    localparam logic [1:0] DIV_OP_QUO = 2'b10;

endpackage

// File: rtl/div_sequencer_step.sv
// One radix-2 restoring division step: shift {rem,quo} left, trial-subtract divisor.
module div_step #(
    parameter int unsigned XLEN = 32
) (
    input  logic [XLEN-1:0] rem_i,
    input  logic [XLEN-1:0] quo_i,
    input  logic [XLEN-1:0] divisor_i,
    output logic [XLEN-1:0] rem_o,
    output logic [XLEN-1:0] quo_o
);

    logic [XLEN:0] shifted;
    logic [XLEN:0] diff;

    always_comb begin
        shifted = {rem_i, quo_i[XLEN-1]};
        // Extra top bit holds the borrow; the shifted remainder is always < 2*divisor.
        diff    = shifted - {1'b0, divisor_i};
        if (!diff[XLEN]) begin
            rem_o = diff[XLEN-1:0];
            quo_o = {quo_i[XLEN-2:0], 1'b1};
        end else begin
            rem_o = shifted[XLEN-1:0];
            quo_o = {quo_i[XLEN-2:0], 1'b0};
        end
    end

endmodule

// File: rtl/div_sequencer.sv
// Multi-cycle signed/unsigned divider: one restoring step per cycle, sign fix-up, held result.
module div_sequencer
    import ZionDataType::*;
#(
    parameter int unsigned XLEN = $bits(CpuType)
) (
    input  logic            iClk,
    input  logic            iRst_n,
    input  logic            iReqValid,
    output logic            oReqReady,
    input  logic [XLEN-1:0] iS1,
    input  logic [XLEN-1:0] iS2,
    input  logic            iSigned,
    input  logic [1:0]      iDivOpEn,
    input  logic            iFlush,
    output logic            oResValid,
    input  logic            iResReady,
    output logic [XLEN-1:0] oResult,
    output logic            oBusy,
    output logic            oDivZero
);

    localparam int unsigned CW = (XLEN > 1) ? $clog2(XLEN) : 1;

    DivState         state_q;
    logic [CW-1:0]   cnt_q;
    logic [XLEN-1:0] rem_q, quo_q, dvsr_q;
    logic            qneg_q, rneg_q;
    logic [1:0]      op_q;
    logic            valid_q, busy_q, divzero_q;
    logic [XLEN-1:0] result_q;

    logic            s1_neg, s2_neg;
    logic [XLEN-1:0] s1_mag, s2_mag;
    logic [XLEN-1:0] rem_d, quo_d;
    logic [XLEN-1:0] quo_fix, rem_fix;

    function automatic logic [XLEN-1:0] sel_result(input logic [1:0] op,
                                                   input logic [XLEN-1:0] quo,
                                                   input logic [XLEN-1:0] rem);
        case (op)
            DIV_OP_QUO: return quo;
            DIV_OP_REM: return rem;
            default:    return '0;
        endcase
    endfunction

    always_comb begin
        s1_neg  = iSigned & iS1[XLEN-1];
        s2_neg  = iSigned & iS2[XLEN-1];
        s1_mag  = s1_neg ? (~iS1 + 1'b1) : iS1;
        s2_mag  = s2_neg ? (~iS2 + 1'b1) : iS2;
        quo_fix = qneg_q ? (~quo_q + 1'b1) : quo_q;
        rem_fix = rneg_q ? (~rem_q + 1'b1) : rem_q;
    end

    div_step #(
        .XLEN(XLEN)
    ) u_step (
        .rem_i     (rem_q),
        .quo_i     (quo_q),
        .divisor_i (dvsr_q),
        .rem_o     (rem_d),
        .quo_o     (quo_d)
    );

    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            rem_q     <= '0;
            quo_q     <= '0;
            dvsr_q    <= '0;
            qneg_q    <= 1'b0;
            rneg_q    <= 1'b0;
            op_q      <= '0;
            valid_q   <= 1'b0;
            busy_q    <= 1'b0;
            divzero_q <= 1'b0;
            result_q  <= '0;
        end else if (iFlush) begin
            state_q   <= IDLE;
            valid_q   <= 1'b0;
            busy_q    <= 1'b0;
            divzero_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (iReqValid) begin
                        op_q   <= iDivOpEn;
                        qneg_q <= s1_neg ^ s2_neg;
                        rneg_q <= s1_neg;
                        dvsr_q <= s2_mag;
                        busy_q <= 1'b1;
                        // Zero divisor bypasses the iteration; remainder is the raw dividend.
                        if (iS2 == '0) begin
                            state_q   <= DONE;
                            valid_q   <= 1'b1;
                            divzero_q <= 1'b1;
                            result_q  <= sel_result(iDivOpEn, '1, iS1);
                        end else begin
                            state_q   <= ITER;
                            cnt_q     <= CW'(XLEN - 1);
                            rem_q     <= '0;
                            quo_q     <= s1_mag;
                            divzero_q <= 1'b0;
                        end
                    end
                end
                ITER: begin
                    rem_q <= rem_d;
                    quo_q <= quo_d;
                    if (cnt_q == '0) begin
                        state_q <= FIX;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                FIX: begin
                    result_q <= sel_result(op_q, quo_fix, rem_fix);
                    valid_q  <= 1'b1;
                    state_q  <= DONE;
                end
                DONE: begin
                    if (iResReady) begin
                        state_q <= IDLE;
                        valid_q <= 1'b0;
                        busy_q  <= 1'b0;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign oReqReady = (state_q == IDLE);
    assign oResValid = valid_q;
    assign oBusy     = busy_q;
    assign oDivZero  = divzero_q;
    assign oResult   = result_q;

endmodule
